// File: rtl/iq_pkg.sv
// ----------------------------------------------------------------------------
// iq_pkg
// Shared definitions for the decode issue queue: RV32 base opcodes used by
// the hazard classifier, the queue entry layout and the per-slot
// classification record.
// No ports (package).
// ----------------------------------------------------------------------------
package iq_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } iq_entry_t;

    typedef struct packed {
        logic       wr;     // writes a non-zero rd
        logic [4:0] rd;
        logic       use1;
        logic [4:0] rs1;
        logic       use2;
        logic [4:0] rs2;
        logic       mem;    // load or store
        logic       ctrl;   // branch, jal or jalr
        logic       known;  // opcode recognised
    } iq_class_t;

endpackage

// File: rtl/decode_issue_queue_if.sv
// ----------------------------------------------------------------------------
// decode_issue_queue_if
// Fetch-side and decode-side bus of the issue queue.
//   in_valid/in_instr/in_pc : fetch group, lane 0 oldest
//   in_ready                : queue can take a full fetch group
//   flush                   : drop everything queued
//   out_valid/out_instr/out_pc : issue group, out_valid is a prefix
//   out_ready               : decode consumes all valid slots
//   split_cnt               : hazard-truncated issue cycles
// master = fetch/decode side, slave = queue.
// ----------------------------------------------------------------------------
interface decode_issue_queue_if #(
    parameter int WIDTH = 2
);
    logic [WIDTH-1:0]       in_valid;
    logic [WIDTH-1:0][31:0] in_instr;
    logic [WIDTH-1:0][31:0] in_pc;
    logic                   in_ready;
    logic                   flush;
    logic [WIDTH-1:0]       out_valid;
    logic [WIDTH-1:0][31:0] out_instr;
    logic [WIDTH-1:0][31:0] out_pc;
    logic                   out_ready;
    logic [31:0]            split_cnt;

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, split_cnt
    );

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_instr, out_pc, split_cnt
    );
endinterface

// File: rtl/issue_hazard_check.sv
// ----------------------------------------------------------------------------
// issue_hazard_check
// Combinational in-order group selector. Classifies the WIDTH head
// instructions and returns the longest legal prefix.
//   i_instr : instructions at head+0 .. head+WIDTH-1
//   i_count : queue occupancy
//   o_valid : issue-slot valid prefix
// ----------------------------------------------------------------------------
module issue_hazard_check
    import iq_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int CNT_W = 4
) (
    input  logic [WIDTH-1:0][31:0] i_instr,
    input  logic [CNT_W-1:0]       i_count,
    output logic [WIDTH-1:0]       o_valid
);

    function automatic iq_class_t classify(
        input logic [6:0] op,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2
    );
        iq_class_t c;
        c       = '0;
        c.rd    = rd;
        c.rs1   = rs1;
        c.rs2   = rs2;
        c.known = 1'b1;
        case (op)
            OP_R:      begin c.wr = 1'b1; c.use1 = 1'b1; c.use2 = 1'b1; end
            OP_IMM:    begin c.wr = 1'b1; c.use1 = 1'b1; end
            OP_LOAD:   begin c.wr = 1'b1; c.use1 = 1'b1; c.mem = 1'b1; end
            OP_STORE:  begin c.use1 = 1'b1; c.use2 = 1'b1; c.mem = 1'b1; end
            OP_BRANCH: begin c.use1 = 1'b1; c.use2 = 1'b1; c.ctrl = 1'b1; end
            OP_JAL:    begin c.wr = 1'b1; c.ctrl = 1'b1; end
            OP_JALR:   begin c.wr = 1'b1; c.use1 = 1'b1; c.ctrl = 1'b1; end
            OP_LUI:    c.wr = 1'b1;
            OP_AUIPC:  c.wr = 1'b1;
            default:   c.known = 1'b0;
        endcase
        // x0 is hardwired, so writing it never creates a dependency
        if (rd == 5'd0) c.wr = 1'b0;
        return c;
    endfunction

    iq_class_t w_cls [WIDTH];
    logic      w_unused_bits;

    always_comb begin
        w_unused_bits = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            w_cls[k] = classify(i_instr[k][6:0], i_instr[k][11:7],
                                i_instr[k][19:15], i_instr[k][24:20]);
            w_unused_bits = w_unused_bits ^ (^{i_instr[k][31:25], i_instr[k][14:12]});
        end
    end

    // Walk the slots oldest-first, accumulating what the group so far writes
    // and whether it already holds a memory op, a control op or an
    // unrecognised instruction. Slot 0 only needs an occupied queue; the
    // accumulators are empty at that point so the same expression covers it.
    always_comb begin
        logic [31:0] wmask;
        logic        mem_seen;
        logic        ctrl_seen;
        logic        stop;
        logic        prev;
        logic        ok;
        o_valid   = '0;
        wmask     = '0;
        mem_seen  = 1'b0;
        ctrl_seen = 1'b0;
        stop      = 1'b0;
        prev      = 1'b1;
        ok        = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            ok = prev
                 && (i_count > CNT_W'(k))
                 && (w_cls[k].known || (k == 0))
                 && !stop
                 && !ctrl_seen
                 && !(mem_seen && w_cls[k].mem)
                 && !(w_cls[k].use1 && wmask[w_cls[k].rs1])
                 && !(w_cls[k].use2 && wmask[w_cls[k].rs2])
                 && !(w_cls[k].wr   && wmask[w_cls[k].rd]);
            o_valid[k] = ok;
            if (ok) begin
                if (w_cls[k].wr) wmask[w_cls[k].rd] = 1'b1;
                mem_seen  = mem_seen  | w_cls[k].mem;
                ctrl_seen = ctrl_seen | w_cls[k].ctrl;
                stop      = stop      | !w_cls[k].known;
            end
            prev = ok;
        end
    end

endmodule

// File: rtl/decode_issue_queue.sv
// ----------------------------------------------------------------------------
// decode_issue_queue
// WIDTH-wide instruction queue between fetch and decode. Buffers up to DEPTH
// instructions, compacts sparse fetch groups on enqueue and issues the
// longest hazard-free in-order group from the head each cycle.
//   clk  : clock
//   rst  : synchronous reset, active high
//   bus  : decode_issue_queue_if slave (fetch in, issue out, flush, split_cnt)
// ----------------------------------------------------------------------------
module decode_issue_queue
    import iq_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    decode_issue_queue_if.slave   bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    iq_entry_t              r_mem [DEPTH];
    logic [PTR_W-1:0]       r_head;
    logic [PTR_W-1:0]       r_tail;
    logic [CNT_W-1:0]       r_count;
    logic [31:0]            r_split_cnt;

    iq_entry_t              w_head_ent [WIDTH];
    logic [WIDTH-1:0][31:0] w_head_instr;
    logic [WIDTH-1:0]       w_out_valid;
    logic                   w_in_ready;
    logic                   w_enq;
    logic                   w_deq;
    logic [CNT_W-1:0]       w_n_in;
    logic [CNT_W-1:0]       w_n_out;
    logic [CNT_W-1:0]       w_avail;
    logic [PTR_W-1:0]       w_wr_idx [WIDTH];

    always_comb begin
        for (int k = 0; k < WIDTH; k++) begin
            w_head_ent[k]   = r_mem[r_head + PTR_W'(k)];
            w_head_instr[k] = w_head_ent[k].instr;
        end
    end

    issue_hazard_check #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_hazard (
        .i_instr (w_head_instr),
        .i_count (r_count),
        .o_valid (w_out_valid)
    );

    // Room for a whole fetch group, judged on the current count only
    assign w_in_ready = (r_count <= CNT_W'(DEPTH - WIDTH));
    assign w_enq      = w_in_ready && !bus.flush;
    assign w_deq      = bus.out_ready && !bus.flush;
    assign w_avail    = (r_count < CNT_W'(WIDTH)) ? r_count : CNT_W'(WIDTH);

    // Each valid lane lands at tail + (number of valid lanes before it)
    always_comb begin
        w_n_in = '0;
        for (int k = 0; k < WIDTH; k++) begin
            w_wr_idx[k] = r_tail + w_n_in[PTR_W-1:0];
            if (bus.in_valid[k]) w_n_in = w_n_in + CNT_W'(1);
        end
    end

    always_comb begin
        w_n_out = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (w_out_valid[k]) w_n_out = w_n_out + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            for (int k = 0; k < WIDTH; k++) begin
                if (bus.in_valid[k]) begin
                    r_mem[w_wr_idx[k]] <= iq_entry_t'{instr: bus.in_instr[k], pc: bus.in_pc[k]};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_split_cnt <= '0;
        end else if (bus.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_tail <= r_tail + w_n_in[PTR_W-1:0];
            if (w_deq) r_head <= r_head + w_n_out[PTR_W-1:0];
            r_count <= r_count + (w_enq ? w_n_in : '0) - (w_deq ? w_n_out : '0);
            // Issued fewer than were available: the group was cut by a hazard
            if (w_deq && (w_n_out < w_avail)) r_split_cnt <= r_split_cnt + 32'd1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.split_cnt = r_split_cnt;

    always_comb begin
        for (int k = 0; k < WIDTH; k++) begin
            bus.out_instr[k] = w_head_ent[k].instr;
            bus.out_pc[k]    = w_head_ent[k].pc;
        end
    end

endmodule

// File: tb/tb_decode_issue_queue.sv
// ----------------------------------------------------------------------------
// tb_decode_issue_queue
// Directed bench for decode_issue_queue at WIDTH=2, DEPTH=8: a table of
// two-instruction groups with expected issue patterns, plus sequences for
// lane compaction, fill/wrap, flush priority, concurrent enq/deq and reset.
// ----------------------------------------------------------------------------
module tb_decode_issue_queue;
    import iq_pkg::*;

    localparam int WIDTH = 2;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst;

    decode_issue_queue_if #(.WIDTH(WIDTH)) bus ();

    decode_issue_queue #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_split = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] f_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, OP_IMM};
    endfunction
    function automatic logic [31:0] f_r(input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {f7, rs2, rs1, 3'b000, rd, OP_R};
    endfunction
    function automatic logic [31:0] f_lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b010, rd, OP_LOAD};
    endfunction
    function automatic logic [31:0] f_sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
    endfunction
    function automatic logic [31:0] f_beq(input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, 5'b0, OP_BRANCH};
    endfunction
    function automatic logic [31:0] f_jal(input logic [4:0] rd);
        return {20'b0, rd, OP_JAL};
    endfunction

    typedef struct {
        string       name;
        logic [31:0] i0;
        logic [31:0] i1;
        logic [1:0]  v1;   // out_valid with both queued
        logic [1:0]  v2;   // out_valid after first dequeue
        int          inc;  // split_cnt increment across the pair
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    logic [31:0] expq [$];
    logic [31:0] pc0;
    int          mcount;

    initial begin
        vecs[0]  = '{"addi_pair",  f_addi(5'd1, 5'd0, 12'd1), f_addi(5'd2, 5'd0, 12'd2), 2'b11, 2'b00, 0};
        vecs[1]  = '{"raw_rs1",    f_r(7'h00, 5'd3, 5'd1, 5'd2), f_r(7'h20, 5'd4, 5'd3, 5'd1), 2'b01, 2'b01, 1};
        vecs[2]  = '{"two_mem",    f_lw(5'd5, 5'd6, 12'd0), f_sw(5'd7, 5'd8, 12'd4), 2'b01, 2'b01, 1};
        vecs[3]  = '{"ctrl_first", f_beq(5'd1, 5'd2), f_addi(5'd3, 5'd0, 12'd1), 2'b01, 2'b01, 1};
        vecs[4]  = '{"ctrl_last",  f_addi(5'd3, 5'd0, 12'd1), f_beq(5'd1, 5'd2), 2'b11, 2'b00, 0};
        vecs[5]  = '{"rd_x0",      f_addi(5'd0, 5'd1, 12'd1), f_r(7'h00, 5'd2, 5'd0, 5'd0), 2'b11, 2'b00, 0};
        vecs[6]  = '{"waw",        f_addi(5'd5, 5'd0, 12'd1), f_addi(5'd5, 5'd0, 12'd2), 2'b01, 2'b01, 1};
        vecs[7]  = '{"unk_slot0",  32'h0000_0000, f_addi(5'd1, 5'd0, 12'd1), 2'b01, 2'b01, 1};
        vecs[8]  = '{"unk_slot1",  f_addi(5'd1, 5'd0, 12'd1), 32'h0000_007f, 2'b01, 2'b01, 1};
        vecs[9]  = '{"raw_rs2",    f_addi(5'd9, 5'd0, 12'd1), f_sw(5'd9, 5'd2, 12'd0), 2'b01, 2'b01, 1};
        vecs[10] = '{"mem_alu",    f_lw(5'd5, 5'd6, 12'd0), f_r(7'h00, 5'd6, 5'd7, 5'd8), 2'b11, 2'b00, 0};
        vecs[11] = '{"jal_first",  f_jal(5'd1), f_addi(5'd3, 5'd0, 12'd1), 2'b01, 2'b01, 1};

        rst           = 1'b1;
        bus.in_valid  = '0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;

        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready), 32'd1);
        chk("rst_split",     bus.split_cnt, 32'd0);
        chk("rst_count",     32'(dut.r_count), 32'd0);

        // ---- table-driven pairs ----
        for (int v = 0; v < NVEC; v++) begin
            pc0 = 32'h1000 + 32'(v * 16);
            bus.in_valid    = 2'b11;
            bus.in_instr[0] = vecs[v].i0;
            bus.in_instr[1] = vecs[v].i1;
            bus.in_pc[0]    = pc0;
            bus.in_pc[1]    = pc0 + 32'd4;
            step();
            bus.in_valid = '0;
            chk($sformatf("%s/v1", vecs[v].name),     32'(bus.out_valid), 32'(vecs[v].v1));
            chk($sformatf("%s/in_ready", vecs[v].name), 32'(bus.in_ready), 32'd1);
            chk($sformatf("%s/instr0", vecs[v].name), bus.out_instr[0], vecs[v].i0);
            chk($sformatf("%s/pc0", vecs[v].name),    bus.out_pc[0], pc0);
            bus.out_ready = 1'b1;
            step();
            chk($sformatf("%s/v2", vecs[v].name), 32'(bus.out_valid), 32'(vecs[v].v2));
            if (vecs[v].v2 != 2'b00) begin
                chk($sformatf("%s/instr1", vecs[v].name), bus.out_instr[0], vecs[v].i1);
                chk($sformatf("%s/pc1", vecs[v].name),    bus.out_pc[0], pc0 + 32'd4);
                step();
            end
            bus.out_ready = 1'b0;
            exp_split = exp_split + 32'(vecs[v].inc);
            chk($sformatf("%s/split", vecs[v].name), bus.split_cnt, exp_split);
            chk($sformatf("%s/count", vecs[v].name), 32'(dut.r_count), 32'd0);
        end

        // ---- sparse fetch group: only lane 1 valid ----
        bus.in_valid    = 2'b10;
        bus.in_instr[0] = f_addi(5'd9, 5'd0, 12'd9);
        bus.in_instr[1] = f_addi(5'd7, 5'd0, 12'd7);
        bus.in_pc[0]    = 32'h2000;
        bus.in_pc[1]    = 32'h2004;
        step();
        bus.in_valid = '0;
        chk("compact_valid", 32'(bus.out_valid), 32'd1);
        chk("compact_instr", bus.out_instr[0], f_addi(5'd7, 5'd0, 12'd7));
        chk("compact_pc",    bus.out_pc[0], 32'h2004);
        chk("compact_count", 32'(dut.r_count), 32'd1);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("compact_drain", 32'(dut.r_count), 32'd0);

        // ---- fill to full with decode stalled, then drain across wrap ----
        mcount = 0;
        for (int g = 0; g < 5; g++) begin
            bus.in_valid    = 2'b11;
            bus.in_instr[0] = f_addi(5'(2 * g + 1), 5'd0, 12'(g));
            bus.in_instr[1] = f_addi(5'(2 * g + 2), 5'd0, 12'(g));
            bus.in_pc[0]    = 32'h4000 + 32'(g * 8);
            bus.in_pc[1]    = 32'h4004 + 32'(g * 8);
            if (mcount <= DEPTH - WIDTH) begin
                expq.push_back(bus.in_instr[0]);
                expq.push_back(bus.in_instr[1]);
                mcount += 2;
            end
            step();
            chk($sformatf("fill%0d_count", g),    32'(dut.r_count), 32'(mcount));
            chk($sformatf("fill%0d_in_ready", g), 32'(bus.in_ready), (mcount <= DEPTH - WIDTH) ? 32'd1 : 32'd0);
        end
        bus.in_valid  = '0;
        bus.out_ready = 1'b1;
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("drain%0d_valid", d),  32'(bus.out_valid), 32'd3);
            chk($sformatf("drain%0d_instr0", d), bus.out_instr[0], expq[0]);
            chk($sformatf("drain%0d_instr1", d), bus.out_instr[1], expq[1]);
            void'(expq.pop_front());
            void'(expq.pop_front());
            step();
        end
        bus.out_ready = 1'b0;
        chk("drain_empty_valid", 32'(bus.out_valid), 32'd0);
        chk("drain_empty_count", 32'(dut.r_count), 32'd0);
        chk("drain_split",       bus.split_cnt, exp_split);

        // ---- flush at count=5 with hazard head, enqueue and dequeue pending ----
        bus.in_valid    = 2'b11;
        bus.in_instr[0] = f_r(7'h00, 5'd3, 5'd1, 5'd2);
        bus.in_instr[1] = f_r(7'h20, 5'd4, 5'd3, 5'd1);
        step();
        bus.in_instr[0] = f_addi(5'd10, 5'd0, 12'd1);
        bus.in_instr[1] = f_addi(5'd11, 5'd0, 12'd1);
        step();
        bus.in_valid    = 2'b01;
        bus.in_instr[0] = f_addi(5'd12, 5'd0, 12'd1);
        step();
        chk("preflush_count", 32'(dut.r_count), 32'd5);
        chk("preflush_valid", 32'(bus.out_valid), 32'd1);
        bus.in_valid  = 2'b11;
        bus.out_ready = 1'b1;
        bus.flush     = 1'b1;
        step();
        bus.flush     = 1'b0;
        bus.in_valid  = '0;
        bus.out_ready = 1'b0;
        chk("flush_count",    32'(dut.r_count), 32'd0);
        chk("flush_valid",    32'(bus.out_valid), 32'd0);
        chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
        chk("flush_split",    bus.split_cnt, exp_split);

        // ---- simultaneous enqueue and dequeue ----
        bus.in_valid    = 2'b11;
        bus.in_instr[0] = f_addi(5'd1, 5'd0, 12'd1);
        bus.in_instr[1] = f_addi(5'd2, 5'd0, 12'd2);
        bus.in_pc[0]    = 32'h3000;
        bus.in_pc[1]    = 32'h3004;
        step();
        chk("post_flush_valid", 32'(bus.out_valid), 32'd3);
        chk("post_flush_instr", bus.out_instr[0], f_addi(5'd1, 5'd0, 12'd1));
        bus.in_instr[0] = f_addi(5'd5, 5'd0, 12'd5);
        bus.in_instr[1] = f_addi(5'd6, 5'd0, 12'd6);
        bus.in_pc[0]    = 32'h3008;
        bus.in_pc[1]    = 32'h300c;
        bus.out_ready   = 1'b1;
        step();
        bus.in_valid  = '0;
        bus.out_ready = 1'b0;
        chk("enqdeq_count",  32'(dut.r_count), 32'd2);
        chk("enqdeq_valid",  32'(bus.out_valid), 32'd3);
        chk("enqdeq_instr0", bus.out_instr[0], f_addi(5'd5, 5'd0, 12'd5));
        chk("enqdeq_pc1",    bus.out_pc[1], 32'h300c);
        chk("enqdeq_split",  bus.split_cnt, exp_split);

        // ---- reset clears split_cnt and the queue ----
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_split", bus.split_cnt, 32'd0);
        chk("rst2_count", 32'(dut.r_count), 32'd0);
        chk("rst2_valid", 32'(bus.out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decode_issue_queue.md
# decode_issue_queue

Parametrised N-wide instruction queue and in-order issue selector between fetch and the superscalar decode stage. It buffers up to DEPTH fetched instructions and each cycle presents the longest legal in-order group from the head, up to WIDTH slots, to the per-slot decoders and the shared register file. It also enforces the intra-group hazard rules the dual-lane decode stage cannot resolve on its own.

## Interface
Parameters:
- WIDTH, 2: fetch/issue slots per cycle; legal 2..4.
- DEPTH, 8: queue entries; power of 2, at least 2*WIDTH.

Ports (lane arrays are indexed 0..WIDTH-1; lane 0 is oldest):
- clk  in  1  clock; the block uses a single clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  WIDTH  per-lane fetch valid.
- in_instr  in  WIDTH x 32  fetched instructions.
- in_pc  in  WIDTH x 32  PC of each lane.
- in_ready  out  1  queue accepts a full fetch group this cycle.
- flush  in  1  discard all queued instructions (redirect or mispredict).
- out_valid  out  WIDTH  issue-slot valid; always a prefix (1s then 0s).
- out_instr  out  WIDTH x 32  instruction per issue slot.
- out_pc  out  WIDTH x 32  PC per issue slot.
- out_ready  in  1  decode stage consumes all valid slots this cycle.
- split_cnt  out  32  count of hazard-truncated issue cycles.

## Operation
- Enqueue occurs when in_ready && !flush. Valid lanes are written in lane order and compacted, so invalid lanes are skipped with no gaps left in the queue. tail advances by popcount(in_valid).
- in_ready = (DEPTH - count) >= WIDTH. It uses the current count and ignores same-cycle dequeue.
- Slot k reads entry head+k (mod DEPTH) and is a candidate when k < count.
- Per-instruction classification is by opcode [6:0]:
  - Writes rd: R 0110011, I-ALU 0010011, LOAD 0000011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111. An rd of x0 counts as no write.
  - Uses rs1: R, I-ALU, LOAD, STORE 0100011, BRANCH 1100011, JALR.
  - Uses rs2: R, STORE, BRANCH.
  - Memory op: LOAD, STORE.
  - Control op: BRANCH, JAL, JALR.
- Slot 0 is valid whenever count >= 1. Slot k>0 is valid only if all of the following hold:
  - slot k-1 is valid;
  - no earlier slot in the group writes a register that slot k uses as rs1 or rs2 (RAW);
  - no earlier slot in the group writes the same non-zero rd as slot k (WAW);
  - slot k is not a memory op when an earlier slot already is;
  - no earlier slot is a control op. A control op may therefore appear only in the last slot.
- An unrecognised opcode is issued alone. It is legal only in slot 0 and terminates the group.
- Dequeue occurs when out_ready && !flush. head advances by popcount(out_valid). Enqueue and dequeue may happen in the same cycle.
- split_cnt increments by 1 in a dequeue cycle when popcount(out_valid) < min(count, WIDTH). It wraps at 2^32.
- Flush sets head = tail = count = 0 at the next edge. It takes priority over same-cycle enqueue and dequeue, and split_cnt is not incremented in that cycle.

## Timing
- Reset, and the value after a flush: head = 0, tail = 0, count = 0, out_valid = 0, in_ready = 1. split_cnt is reset to 0 by reset only; flush does not clear it.
- out_valid, out_instr and out_pc are combinational from registered queue state. There is no combinational path from in_* or out_ready to out_*.
- Latency from enqueue to visibility on out_* is 1 cycle minimum.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- Full: count = DEPTH, which implies in_ready = 0.
- Empty: out_valid = 0, and out_ready is ignored.
- When out_valid = 0, out_instr and out_pc are don't-care. The bench must not check them.

## Structure
- Shared package iq_pkg holds:
  - opcode localparams: OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC;
  - the iq_entry_t struct (instr, pc);
  - the iq_class_t struct (wr, rd, use1, rs1, use2, rs2, mem, ctrl, known).
- One combinational sub-module, issue_hazard_check. It takes the WIDTH head entries and count, and returns the out_valid prefix. It also contains the per-slot opcode classifier.
- The top level holds the storage array, the pointers and count, enqueue compaction, and split_cnt.

## Test plan
- Reset, then enqueue ADDI x1 and ADDI x2 with WIDTH=2 -> the next cycle gives out_valid=11 and in_ready=1. After the group is dequeued, count returns to 0.
- ADD x3,x1,x2 followed by SUB x4,x3,x1 -> first cycle out_valid=01 with split_cnt=1; next cycle SUB issues alone with out_valid=01.
- LW x5,0(x6) followed by SW x7,4(x8) -> issued as two single-slot groups. BEQ then ADDI -> BEQ issues alone. ADDI then BEQ -> both issue, out_valid=11.
- ADDI x0,x1,1 followed by ADD x2,x0,x0 -> no hazard because rd=x0; out_valid=11.
- DEPTH=8 with out_ready=0 and four full fetch groups -> in_ready drops after 6 entries, and count stops at 6 or 8 and never exceeds DEPTH. Drain then verifies order across pointer wrap.
- flush asserted together with in_valid=11 and out_ready=1 at count=5 -> the next cycle gives count=0, out_valid=00, and split_cnt unchanged.
